core_control_fsm: RTL and testbench
===================================

# core_control_fsm

Multi-cycle sequencer for the RV32IMA core. It steps each instruction through fetch, decode, execute, memory, multiply/divide wait, writeback and trap handling. It consumes the instruction decoder's category flags and drives the instruction register, PC, register file, CSR, multiply/divide unit and memory handshakes. One instruction is in flight at a time.

## Interface
No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request; held until imem_ready
- imem_ready  in  1  fetch data valid this cycle
- ir_we  out  1  load instruction register
- dec_is_load, dec_is_store, dec_is_branch, dec_is_jal, dec_is_jalr, dec_is_lui, dec_is_auipc, dec_is_alu_reg, dec_is_alu_imm, dec_is_system, dec_is_fence, dec_is_mul, dec_is_div, dec_is_atomic, dec_illegal  in  1 each  decoder flags for the current IR
- dec_funct3  in  3  IR[14:12]
- dec_funct12  in  12  IR[31:20]
- branch_taken  in  1  branch comparison result
- md_start  out  1  one-cycle start pulse to mul/div unit
- md_done  in  1  mul/div result valid
- dmem_req  out  1  data request; held until dmem_ready
- dmem_we  out  1  write qualifier for dmem_req
- amo_phase  out  1  0 = AMO read phase, 1 = AMO write phase
- dmem_ready  in  1  data access complete
- dmem_err  in  1  access fault; qualified by dmem_ready
- irq_pending  in  1  enabled machine interrupt pending
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = rs1+imm, 11 = CSR-supplied (mtvec on trap, mepc on mret)
- rf_we  out  1  register write strobe; the register file ignores x0
- wb_sel  out  3  0 = ALU, 1 = memory, 2 = PC+4, 3 = CSR, 4 = mul/div
- csr_we  out  1  CSR instruction access strobe
- trap_enter  out  1  one-cycle trap-entry pulse
- trap_cause  out  5  bit4 = interrupt; bits 3:0 = exception code
- mret  out  1  one-cycle mret pulse
- instret  out  1  one-cycle pulse per retired instruction

## Operation
- States: RESET, FETCH, DECODE, EXECUTE, MEM, AMO_WR, MD_WAIT, TRAP.
- RESET:
  - Entered asynchronously while rst_n is low; all outputs are 0.
  - Moves to FETCH on the first clk edge after rst_n rises.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1, go to DECODE.
- DECODE (one cycle):
  - dec_illegal → TRAP, cause 2.
  - Otherwise → EXECUTE.
- EXECUTE by category:
  - ALU reg/imm, LUI, AUIPC: rf_we, wb_sel 0, pc_sel 00.
  - JAL: rf_we, wb_sel 2, pc_sel 01.
  - JALR: rf_we, wb_sel 2, pc_sel 10.
  - Branch: pc_sel 01 if branch_taken, else 00.
  - Fence: NOP, pc_sel 00.
  - WFI (funct3 0, funct12 0x105): NOP, pc_sel 00.
  - CSR (funct3 ≠ 0): csr_we, rf_we, wb_sel 3, pc_sel 00.
  - Each of the above sets pc_we and instret, then returns to FETCH.
  - MRET (funct3 0, funct12 0x302): mret, pc_we, pc_sel 11, instret → FETCH.
  - ECALL (funct12 0x000) → TRAP, cause 11.
  - EBREAK (funct12 0x001) → TRAP, cause 3.
  - Any other funct12 with funct3 0 → TRAP, cause 2.
  - Load, store or atomic → MEM.
  - Mul or div: md_start=1 → MD_WAIT.
- MEM:
  - dmem_req=1; dmem_we=1 for store only; amo_phase=0.
  - On dmem_ready with dmem_err → TRAP. Cause 5 for a load; cause 7 for a store or atomic.
  - On dmem_ready without error:
    - Load: rf_we, wb_sel 1, retire.
    - Store: retire.
    - Atomic: rf_we, wb_sel 1 → AMO_WR.
- AMO_WR:
  - dmem_req=1, dmem_we=1, amo_phase=1.
  - On dmem_ready: error → TRAP, cause 7; otherwise retire.
- MD_WAIT:
  - md_done is sampled only in this state.
  - On md_done: rf_we, wb_sel 4, retire.
- Retire means pc_we=1, pc_sel=00, instret=1.
- Interrupt check, on every retire cycle:
  - irq_pending=1 → next state TRAP with cause 5'b1_1011, instead of FETCH.
  - The PC update in that cycle completes first, so mepc captures the next instruction.
- TRAP (one cycle):
  - trap_enter=1, pc_we=1, pc_sel=11, trap_cause valid.
  - No rf_we, no instret → FETCH.
- An exception (illegal instruction, ECALL, EBREAK, access fault) never asserts pc_we or rf_we in the faulting cycle, and never sets instret.

## Timing
- All outputs are combinational from the state register plus the handshake inputs (imem_ready, dmem_ready, dmem_err, md_done, branch_taken).
- Reset value of the state register is RESET; every output reads 0 during and immediately after reset.
- Minimum latencies in cycles, counted FETCH to the next FETCH with zero-wait memories:
  - ALU, branch, jump, CSR: 3.
  - Load or store: 4.
  - Atomic: 5.
  - Mul/div: 4 + unit latency.
  - Trap: +1.
- imem_req and dmem_req stay asserted, with dmem_we and amo_phase stable, until their ready is seen. They drop in the cycle after ready.
- A ready with no request asserted is ignored.
- trap_enter and mret are never asserted in the same cycle.
- Asynchronous reset in any state aborts the instruction, drops all requests immediately and returns to RESET.

## Test plan
- Reset release, imem_ready asserted on the 2nd FETCH cycle → imem_req high 2 cycles, ir_we exactly once, DECODE follows.
- ADDI with zero-wait fetch → rf_we, pc_we, instret in cycle 3; pc_sel=00; wb_sel=0.
- LW with dmem_ready after 3 wait cycles → dmem_req high 4 cycles with dmem_we=0, then rf_we and wb_sel=1 on the ready cycle.
- SW with dmem_err on ready → trap_enter, trap_cause=7, no instret; next state FETCH.
- Undecodable instruction (dec_illegal=1) → TRAP after DECODE with cause 2. ECALL → cause 11. EBREAK → cause 3. MRET → mret pulse with pc_sel=11.
- DIV with md_done after 33 cycles, irq_pending high at retire → md_start pulsed once, rf_we with wb_sel=4, then trap_enter with cause 5'b1_1011.

Source files
------------

// File: rtl/core_control_fsm.sv
// core_control_fsm: multi-cycle sequencer for the RV32IMA core.
// Steps one instruction at a time through fetch, decode, execute, memory,
// AMO write-back, mul/div wait and trap entry. Every output is a function
// of the state register, the latched trap cause, the decoder flags of the
// held instruction and the handshake inputs.
module core_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_branch,
  input  logic        dec_is_jal,
  input  logic        dec_is_jalr,
  input  logic        dec_is_lui,
  input  logic        dec_is_auipc,
  input  logic        dec_is_alu_reg,
  input  logic        dec_is_alu_imm,
  input  logic        dec_is_system,
  input  logic        dec_is_fence,
  input  logic        dec_is_mul,
  input  logic        dec_is_div,
  input  logic        dec_is_atomic,
  input  logic        dec_illegal,
  input  logic [2:0]  dec_funct3,
  input  logic [11:0] dec_funct12,
  input  logic        branch_taken,
  output logic        md_start,
  input  logic        md_done,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        amo_phase,
  input  logic        dmem_ready,
  input  logic        dmem_err,
  input  logic        irq_pending,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [2:0]  wb_sel,
  output logic        csr_we,
  output logic        trap_enter,
  output logic [4:0]  trap_cause,
  output logic        mret,
  output logic        instret
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_AMO_WR  = 3'd5,
    S_MD_WAIT = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [1:0]  PC_PLUS4 = 2'b00;
  localparam logic [1:0]  PC_IMM   = 2'b01;
  localparam logic [1:0]  PC_RS1   = 2'b10;
  localparam logic [1:0]  PC_CSR   = 2'b11;

  localparam logic [2:0]  WB_ALU   = 3'd0;
  localparam logic [2:0]  WB_MEM   = 3'd1;
  localparam logic [2:0]  WB_PC4   = 3'd2;
  localparam logic [2:0]  WB_CSR   = 3'd3;
  localparam logic [2:0]  WB_MD    = 3'd4;

  localparam logic [4:0]  CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0]  CAUSE_BREAK   = 5'd3;
  localparam logic [4:0]  CAUSE_LD_FLT  = 5'd5;
  localparam logic [4:0]  CAUSE_ST_FLT  = 5'd7;
  localparam logic [4:0]  CAUSE_ECALL   = 5'd11;
  localparam logic [4:0]  CAUSE_IRQ     = 5'b1_1011;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_WFI    = 12'h105;
  localparam logic [11:0] F12_MRET   = 12'h302;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cause;
  logic [4:0]  w_cause;
  logic        w_cause_we;
  logic        w_retire;
  logic        w_sys_priv;
  logic        w_simple_alu;

  // Privileged SYSTEM encodings (ECALL/EBREAK/MRET/WFI) all have funct3 == 0.
  assign w_sys_priv   = dec_is_system && (dec_funct3 == 3'd0);
  assign w_simple_alu = dec_is_alu_reg | dec_is_alu_imm | dec_is_lui | dec_is_auipc;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  // Trap cause is latched on the transition into TRAP and presented there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cause <= 5'd0;
    else if (w_cause_we) r_cause <= w_cause;
  end

  // Next-state and output decode; retire and interrupt redirect handled at the end.
  always_comb begin
    w_next     = r_state;
    w_cause    = 5'd0;
    w_cause_we = 1'b0;
    w_retire   = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    md_start   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    amo_phase  = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    csr_we     = 1'b0;
    trap_enter = 1'b0;
    trap_cause = 5'd0;
    mret       = 1'b0;
    instret    = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          w_next     = S_TRAP;
          w_cause    = CAUSE_ILLEGAL;
          w_cause_we = 1'b1;
        end else begin
          w_next = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        if (dec_is_load || dec_is_store || dec_is_atomic) begin
          w_next = S_MEM;
        end else if (dec_is_mul || dec_is_div) begin
          md_start = 1'b1;
          w_next   = S_MD_WAIT;
        end else if (w_simple_alu) begin
          rf_we    = 1'b1;
          wb_sel   = WB_ALU;
          w_retire = 1'b1;
        end else if (dec_is_jal) begin
          rf_we    = 1'b1;
          wb_sel   = WB_PC4;
          pc_sel   = PC_IMM;
          w_retire = 1'b1;
        end else if (dec_is_jalr) begin
          rf_we    = 1'b1;
          wb_sel   = WB_PC4;
          pc_sel   = PC_RS1;
          w_retire = 1'b1;
        end else if (dec_is_branch) begin
          pc_sel   = branch_taken ? PC_IMM : PC_PLUS4;
          w_retire = 1'b1;
        end else if (dec_is_fence) begin
          w_retire = 1'b1;
        end else if (dec_is_system && !w_sys_priv) begin
          csr_we   = 1'b1;
          rf_we    = 1'b1;
          wb_sel   = WB_CSR;
          w_retire = 1'b1;
        end else if (w_sys_priv && dec_funct12 == F12_WFI) begin
          w_retire = 1'b1;
        end else if (w_sys_priv && dec_funct12 == F12_MRET) begin
          mret     = 1'b1;
          pc_sel   = PC_CSR;
          w_retire = 1'b1;
        end else begin
          // ECALL, EBREAK, unknown privileged op, or no category flag at all.
          w_next     = S_TRAP;
          w_cause_we = 1'b1;
          if (w_sys_priv && dec_funct12 == F12_ECALL)       w_cause = CAUSE_ECALL;
          else if (w_sys_priv && dec_funct12 == F12_EBREAK) w_cause = CAUSE_BREAK;
          else                                               w_cause = CAUSE_ILLEGAL;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        if (dmem_ready) begin
          if (dmem_err) begin
            w_next     = S_TRAP;
            w_cause    = dec_is_load ? CAUSE_LD_FLT : CAUSE_ST_FLT;
            w_cause_we = 1'b1;
          end else if (dec_is_load) begin
            rf_we    = 1'b1;
            wb_sel   = WB_MEM;
            w_retire = 1'b1;
          end else if (dec_is_store) begin
            w_retire = 1'b1;
          end else begin
            rf_we  = 1'b1;
            wb_sel = WB_MEM;
            w_next = S_AMO_WR;
          end
        end
      end

      S_AMO_WR: begin
        dmem_req  = 1'b1;
        dmem_we   = 1'b1;
        amo_phase = 1'b1;
        if (dmem_ready) begin
          if (dmem_err) begin
            w_next     = S_TRAP;
            w_cause    = CAUSE_ST_FLT;
            w_cause_we = 1'b1;
          end else begin
            w_retire = 1'b1;
          end
        end
      end

      S_MD_WAIT: begin
        if (md_done) begin
          rf_we    = 1'b1;
          wb_sel   = WB_MD;
          w_retire = 1'b1;
        end
      end

      S_TRAP: begin
        trap_enter = 1'b1;
        trap_cause = r_cause;
        pc_we      = 1'b1;
        pc_sel     = PC_CSR;
        w_next     = S_FETCH;
      end

      default: begin
        w_next = S_RESET;
      end
    endcase

    // The retiring PC update still happens when an interrupt is taken, so
    // mepc ends up pointing at the next instruction.
    if (w_retire) begin
      pc_we   = 1'b1;
      instret = 1'b1;
      if (irq_pending) begin
        w_next     = S_TRAP;
        w_cause    = CAUSE_IRQ;
        w_cause_we = 1'b1;
      end else begin
        w_next = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_core_control_fsm.sv
// tb_core_control_fsm: directed stimulus for core_control_fsm with a
// scoreboard of expected control events checked by a separate monitor.
module tb_core_control_fsm;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_ready, ir_we;
  logic [14:0] r_dec;
  logic [2:0]  dec_funct3;
  logic [11:0] dec_funct12;
  logic        branch_taken, md_start, md_done;
  logic        dmem_req, dmem_we, amo_phase, dmem_ready, dmem_err;
  logic        irq_pending, pc_we, rf_we, csr_we, trap_enter, mret, instret;
  logic [1:0]  pc_sel;
  logic [2:0]  wb_sel;
  logic [4:0]  trap_cause;

  localparam int D_LOAD = 0, D_STORE = 1, D_BRANCH = 2, D_JAL = 3, D_JALR = 4;
  localparam int D_LUI = 5, D_AUIPC = 6, D_ALUR = 7, D_ALUI = 8, D_SYS = 9;
  localparam int D_FENCE = 10, D_MUL = 11, D_DIV = 12, D_ATOM = 13, D_ILL = 14;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] sb_q[$];
  logic [16:0] mon_exp;

  core_control_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_is_load(r_dec[D_LOAD]), .dec_is_store(r_dec[D_STORE]),
    .dec_is_branch(r_dec[D_BRANCH]), .dec_is_jal(r_dec[D_JAL]),
    .dec_is_jalr(r_dec[D_JALR]), .dec_is_lui(r_dec[D_LUI]),
    .dec_is_auipc(r_dec[D_AUIPC]), .dec_is_alu_reg(r_dec[D_ALUR]),
    .dec_is_alu_imm(r_dec[D_ALUI]), .dec_is_system(r_dec[D_SYS]),
    .dec_is_fence(r_dec[D_FENCE]), .dec_is_mul(r_dec[D_MUL]),
    .dec_is_div(r_dec[D_DIV]), .dec_is_atomic(r_dec[D_ATOM]),
    .dec_illegal(r_dec[D_ILL]),
    .dec_funct3(dec_funct3), .dec_funct12(dec_funct12),
    .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .amo_phase(amo_phase),
    .dmem_ready(dmem_ready), .dmem_err(dmem_err),
    .irq_pending(irq_pending),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .csr_we(csr_we), .trap_enter(trap_enter), .trap_cause(trap_cause),
    .mret(mret), .instret(instret)
  );

  wire [16:0] w_obs = {pc_we, pc_sel, rf_we, wb_sel, csr_we, md_start,
                       trap_enter, trap_cause, mret, instret};
  wire [23:0] w_all = {imem_req, ir_we, md_start, dmem_req, dmem_we, amo_phase,
                       pc_we, pc_sel, rf_we, wb_sel, csr_we, trap_enter,
                       trap_cause, mret, instret};
  wire        w_event = pc_we | rf_we | md_start | trap_enter | mret | instret | csr_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ev(input logic pcwe, input logic [1:0] psel,
                                     input logic rfwe, input logic [2:0] wb,
                                     input logic csrwe, input logic mds,
                                     input logic te, input logic [4:0] tc,
                                     input logic mr, input logic ir);
    return {pcwe, psel, rfwe, wb, csrwe, mds, te, tc, mr, ir};
  endfunction

  function automatic logic [16:0] ev_ret(input logic [1:0] psel, input logic rfwe,
                                         input logic [2:0] wb);
    return ev(1'b1, psel, rfwe, wb, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endfunction

  function automatic logic [16:0] ev_trap(input logic [4:0] cause);
    return ev(1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, cause, 1'b0, 1'b0);
  endfunction

  // Monitor: every cycle with a control strobe must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && w_event) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected actual=%05h required=none", w_obs);
        end else begin
          mon_exp = sb_q.pop_front();
          if (w_obs !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_event actual=%05h required=%05h", w_obs, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_set(input int idx, input logic [2:0] f3, input logic [11:0] f12);
    r_dec       = '0;
    r_dec[idx]  = 1'b1;
    dec_funct3  = f3;
    dec_funct12 = f12;
  endtask

  // Fetch with w wait cycles before imem_ready; leaves the DUT in DECODE.
  task automatic fetch(input int w, input string nm);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk({nm, "_imem_req_wait"}, imem_req, 1);
      chk({nm, "_ir_we_wait"}, ir_we, 0);
      cyc();
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_imem_req_rdy"}, imem_req, 1);
    chk({nm, "_ir_we_rdy"}, ir_we, 1);
    chk({nm, "_no_dmem_req"}, dmem_req, 0);
    cyc();
    imem_ready = 1'b0;
  endtask

  task automatic decode(input string nm);
    @(negedge clk);
    chk({nm, "_dec_imem_req"}, imem_req, 0);
    chk({nm, "_dec_ir_we"}, ir_we, 0);
    cyc();
  endtask

  // One memory phase: w wait cycles then a ready cycle (optionally with error).
  task automatic mem_phase(input int w, input logic we, input logic amo,
                           input logic err, input string nm);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk({nm, "_dmem_req"}, dmem_req, 1);
      chk({nm, "_dmem_we"}, dmem_we, we);
      chk({nm, "_amo_phase"}, amo_phase, amo);
      cyc();
    end
    dmem_ready = 1'b1;
    dmem_err   = err;
    @(negedge clk);
    chk({nm, "_dmem_req_rdy"}, dmem_req, 1);
    chk({nm, "_dmem_we_rdy"}, dmem_we, we);
    chk({nm, "_amo_phase_rdy"}, amo_phase, amo);
    cyc();
    dmem_ready = 1'b0;
    dmem_err   = 1'b0;
  endtask

  // Short single-cycle-execute instruction: fetch, decode, one event cycle.
  task automatic simple(input int idx, input logic [2:0] f3, input logic [11:0] f12,
                        input logic [16:0] e, input string nm);
    dec_set(idx, f3, f12);
    fetch(0, nm);
    decode(nm);
    sb_q.push_back(e);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; r_dec = '0; dec_funct3 = 3'd0;
    dec_funct12 = 12'd0; branch_taken = 1'b0; md_done = 1'b0;
    dmem_ready = 1'b0; dmem_err = 1'b0; irq_pending = 1'b0;

    // Reset: outputs quiet during and right after release, stray readies ignored.
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_outs", w_all, 0);
    rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("post_reset_outs", w_all, 0);
    cyc();
    imem_ready = 1'b0; dmem_ready = 1'b0;

    // First fetch ready on second FETCH cycle, then ADDI.
    dec_set(D_ALUI, 3'd0, 12'd5);
    fetch(1, "t1");
    decode("t1");
    sb_q.push_back(ev_ret(2'b00, 1'b1, 3'd0));
    cyc();

    // ADDI with md_done asserted outside MD_WAIT: must be ignored.
    md_done = 1'b1;
    simple(D_ALUI, 3'd0, 12'd1, ev_ret(2'b00, 1'b1, 3'd0), "addi");
    md_done = 1'b0;

    // LW with three wait cycles.
    dec_set(D_LOAD, 3'd2, 12'd0);
    fetch(0, "lw"); decode("lw"); cyc();
    sb_q.push_back(ev_ret(2'b00, 1'b1, 3'd1));
    mem_phase(3, 1'b0, 1'b0, 1'b0, "lw");

    // SW with access fault on ready: trap cause 7 in the following cycle.
    dec_set(D_STORE, 3'd2, 12'd0);
    fetch(0, "sw"); decode("sw"); cyc();
    sb_q.push_back(ev_trap(5'd7));
    mem_phase(0, 1'b1, 1'b0, 1'b1, "sw");
    cyc();

    // Illegal instruction traps straight out of DECODE.
    dec_set(D_ILL, 3'd0, 12'd0);
    fetch(0, "ill");
    sb_q.push_back(ev_trap(5'd2));
    cyc(); cyc();

    // ECALL, EBREAK and unknown privileged op.
    simple(D_SYS, 3'd0, 12'h000, ev_trap(5'd11), "ecall"); cyc();
    simple(D_SYS, 3'd0, 12'h001, ev_trap(5'd3), "ebreak"); cyc();
    simple(D_SYS, 3'd0, 12'h7FF, ev_trap(5'd2), "badpriv"); cyc();

    // MRET, jumps, branches, CSR, WFI, FENCE.
    simple(D_SYS, 3'd0, 12'h302,
           ev(1'b1, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1), "mret");
    simple(D_JAL, 3'd0, 12'd0, ev_ret(2'b01, 1'b1, 3'd2), "jal");
    simple(D_JALR, 3'd0, 12'd0, ev_ret(2'b10, 1'b1, 3'd2), "jalr");
    branch_taken = 1'b1;
    simple(D_BRANCH, 3'd0, 12'd0, ev_ret(2'b01, 1'b0, 3'd0), "beq_t");
    branch_taken = 1'b0;
    simple(D_BRANCH, 3'd1, 12'd0, ev_ret(2'b00, 1'b0, 3'd0), "bne_nt");
    simple(D_SYS, 3'd1, 12'h300,
           ev(1'b1, 2'b00, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), "csrrw");
    simple(D_SYS, 3'd0, 12'h105, ev_ret(2'b00, 1'b0, 3'd0), "wfi");
    simple(D_FENCE, 3'd0, 12'd0, ev_ret(2'b00, 1'b0, 3'd0), "fence");
    simple(D_LUI, 3'd0, 12'd0, ev_ret(2'b00, 1'b1, 3'd0), "lui");

    // Atomic: read phase writes the register, write phase retires.
    dec_set(D_ATOM, 3'd2, 12'd0);
    fetch(0, "amo"); decode("amo"); cyc();
    sb_q.push_back(ev(1'b0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    mem_phase(1, 1'b0, 1'b0, 1'b0, "amo_rd");
    sb_q.push_back(ev_ret(2'b00, 1'b0, 3'd0));
    mem_phase(0, 1'b1, 1'b1, 1'b0, "amo_wr");

    // DIV with a long unit latency and an interrupt pending at retire.
    dec_set(D_DIV, 3'd4, 12'd0);
    fetch(0, "div"); decode("div");
    sb_q.push_back(ev(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0));
    cyc();
    repeat (32) cyc();
    md_done = 1'b1; irq_pending = 1'b1;
    sb_q.push_back(ev_ret(2'b00, 1'b1, 3'd4));
    sb_q.push_back(ev_trap(5'b1_1011));
    cyc();
    md_done = 1'b0; irq_pending = 1'b0;
    cyc();

    // Asynchronous reset in the middle of a load drops the request at once.
    dec_set(D_LOAD, 3'd2, 12'd0);
    fetch(0, "rst"); decode("rst"); cyc();
    @(negedge clk);
    chk("rst_dmem_req_before", dmem_req, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_abort", w_all, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    simple(D_ALUR, 3'd0, 12'd0, ev_ret(2'b00, 1'b1, 3'd0), "add_after_rst");

    repeat (3) cyc();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
